// File: rtl/spi_slave_sync_bit.sv
// rtl/spi_slave_sync_bit.sv - single-bit multi-stage synchronizer with reset init value
module sync_bit #(
    parameter int   SYNC = 2,
    parameter logic INIT = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [SYNC-1:0] chain;

    // Shift the asynchronous input through SYNC flops; reset parks the chain at INIT
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            chain <= {SYNC{INIT}};
        end else begin
            chain <= {chain[SYNC-2:0], din};
        end
    end

    assign dout = chain[SYNC-1];

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI mode 0 responder, MSB first, 8-bit frames
module spi_slave #(
    parameter int SYNC = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       spi_ck,
    input  logic       spi_ss_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    input  logic [7:0] d,
    output logic [7:0] q,
    output logic       rx,
    output logic       first,
    output logic       busy
);

    localparam int W  = 8;
    localparam int BW = $clog2(W);
    localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);
    localparam logic [1:0]    WARM_MAX = 2'(SYNC);

    typedef enum logic {
        S_IDLE,
        S_SEL
    } state_t;

    state_t state_q, state_d;

    logic ck_s, ss_s, mosi_s;
    logic ck_d, ss_d;
    logic [1:0] warm;
    logic armed;
    logic sck_rise, sck_fall, ss_fall, ss_rise;

    logic [BW-1:0] bit_cnt;
    logic [7:0]    byte_idx;
    logic [W-1:0]  rx_sr;
    logic [W-1:0]  tx_sr;
    logic          pend;
    logic          pend_first;

    sync_bit #(.SYNC(SYNC), .INIT(1'b0)) u_sync_ck (
        .clock(clock), .reset(reset), .din(spi_ck), .dout(ck_s)
    );
    sync_bit #(.SYNC(SYNC), .INIT(1'b1)) u_sync_ss (
        .clock(clock), .reset(reset), .din(spi_ss_n), .dout(ss_s)
    );
    sync_bit #(.SYNC(SYNC), .INIT(1'b1)) u_sync_mosi (
        .clock(clock), .reset(reset), .din(spi_mosi), .dout(mosi_s)
    );

    // Edge-detect delay registers; armed only once the synced SS_n has truly been seen high,
    // so a select held low across reset release does not look like a frame start
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ck_d  <= 1'b0;
            ss_d  <= 1'b1;
            warm  <= 2'd0;
            armed <= 1'b0;
        end else begin
            ck_d <= ck_s;
            ss_d <= ss_s;
            if (warm != WARM_MAX) begin
                warm <= warm + 2'd1;
            end
            if (warm == WARM_MAX && ss_s) begin
                armed <= 1'b1;
            end
        end
    end

    assign sck_rise = ck_s & ~ck_d;
    assign sck_fall = ~ck_s & ck_d;
    assign ss_fall  = armed & ss_d & ~ss_s;
    assign ss_rise  = ss_s & ~ss_d;

    // Select state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Select state transitions on the synchronized SS_n edges
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (ss_fall) state_d = S_SEL;
            S_SEL:  if (ss_rise) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Shift registers, counters and the delivered-byte strobe
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bit_cnt    <= '0;
            byte_idx   <= 8'd0;
            rx_sr      <= '1;
            tx_sr      <= '1;
            pend       <= 1'b0;
            pend_first <= 1'b0;
            q          <= 8'h00;
            rx         <= 1'b0;
            first      <= 1'b0;
        end else begin
            rx    <= 1'b0;
            first <= 1'b0;
            pend  <= 1'b0;
            // A completed byte is delivered even if SS rose in the same cycle
            if (pend) begin
                q     <= rx_sr;
                rx    <= 1'b1;
                first <= pend_first;
            end
            if (state_q == S_IDLE) begin
                bit_cnt  <= '0;
                byte_idx <= 8'd0;
                if (ss_fall) begin
                    tx_sr <= d;
                end
            end else begin
                if (sck_rise) begin
                    rx_sr   <= {rx_sr[W-2:0], mosi_s};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        pend       <= 1'b1;
                        pend_first <= (byte_idx == 8'd0);
                        if (byte_idx != 8'hFF) begin
                            byte_idx <= byte_idx + 8'd1;
                        end
                    end
                end else if (sck_fall) begin
                    if (bit_cnt == '0 && byte_idx != 8'd0) begin
                        tx_sr <= d;
                    end else begin
                        tx_sr <= {tx_sr[W-2:0], 1'b1};
                    end
                end
                if (ss_rise) begin
                    bit_cnt  <= '0;
                    byte_idx <= 8'd0;
                    tx_sr    <= '1;
                end
            end
        end
    end

    assign busy        = (state_q == S_SEL);
    assign spi_miso_oe = busy;
    assign spi_miso    = busy ? tx_sr[W-1] : 1'b1;

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - scoreboard bench for spi_slave with randomized frames
module tb_spi_slave;

    localparam int SYNC = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       spi_ck = 1'b0;
    logic       spi_ss_n = 1'b1;
    logic       spi_mosi = 1'b1;
    logic [7:0] d;
    logic       spi_miso, spi_miso_oe, rx, first, busy;
    logic [7:0] q;

    int checks = 0;
    int errors = 0;

    logic [8:0] exp_q[$];
    logic [7:0] d_next[$];
    logic [7:0] d_preset = 8'h00;
    int         preset_seq = 0;

    spi_slave #(.SYNC(SYNC)) dut (
        .clock(clock), .reset(reset), .spi_ck(spi_ck), .spi_ss_n(spi_ss_n),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .d(d), .q(q), .rx(rx), .first(first), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic preset(input logic [7:0] v);
        d_preset = v;
        preset_seq++;
        idle(2);
    endtask

    task automatic check_reset_values();
        check("rst_q", q, 8'h00);
        check("rst_rx", rx, 1'b0);
        check("rst_first", first, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_miso", spi_miso, 1'b1);
        check("rst_miso_oe", spi_miso_oe, 1'b0);
    endtask

    // Initiator: sends mo, compares MISO bytes with mi, stops after stop_bits rises if nonzero
    task automatic frame(input logic [7:0] mo[$], input logic [7:0] mi[$],
                         input int half, input int stop_bits);
        logic [7:0] got = 8'h00;
        int nb = 0;
        spi_ss_n = 1'b0;
        idle(half + SYNC + 2);
        check("sel_busy", busy, 1'b1);
        for (int i = 0; i < mo.size(); i++) begin
            for (int b = 7; b >= 0; b--) begin
                spi_mosi = mo[i][b];
                idle(half);
                got = {got[6:0], spi_miso};
                spi_ck = 1'b1;
                nb++;
                if (b == 0) exp_q.push_back({(i == 0), mo[i]});
                idle(half);
                spi_ck = 1'b0;
                if (nb == stop_bits) begin
                    idle(half);
                    spi_ss_n = 1'b1;
                    idle(half + SYNC + 4);
                    return;
                end
            end
            if (i < mi.size()) check("miso_byte", got, mi[i]);
        end
        idle(half);
        spi_ss_n = 1'b1;
        idle(half + SYNC + 4);
        check("idle_busy", busy, 1'b0);
    endtask

    // Monitor: pops the scoreboard on every rx and plays the core updating d
    initial begin
        int seen = 0;
        logic [8:0] e;
        d = 8'h00;
        forever begin
            @(negedge clock);
            if (preset_seq != seen) begin
                seen = preset_seq;
                d = d_preset;
            end
            if (rx === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("rx_unexpected", {31'b0, rx}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_q", q, e[7:0]);
                    check("rx_first", first, e[8]);
                end
                if (d_next.size() > 0) d = d_next.pop_front();
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] mo[$];
        logic [7:0] mi[$];
        logic [7:0] pv;
        int len, half;

        reset = 1'b0;
        idle(3);
        check_reset_values();
        reset = 1'b1;
        idle(8);

        // single byte
        preset(8'h3C);
        mo = '{8'hA5};
        mi = '{8'h3C};
        frame(mo, mi, 4, 0);
        check("single_q", q, 8'hA5);

        // three-byte frame, core answers each rx with the next d
        preset(8'h3C);
        d_next = '{8'h11, 8'h22, 8'h33};
        mo = '{8'h01, 8'h80, 8'hFF};
        mi = '{8'h3C, 8'h11, 8'h22};
        frame(mo, mi, 8, 0);

        // abort after 5 rises, q holds
        mo = '{8'hF0};
        mi = {};
        frame(mo, mi, 8, 5);
        check("abort_q_held", q, 8'hFF);
        mo = '{8'h5A};
        frame(mo, mi, 8, 0);
        check("after_abort_q", q, 8'h5A);

        // reset mid-byte with SS held low
        preset(8'h77);
        spi_ss_n = 1'b0;
        idle(8);
        for (int i = 0; i < 3; i++) begin
            spi_mosi = 1'b1;
            idle(6);
            spi_ck = 1'b1;
            idle(6);
            spi_ck = 1'b0;
        end
        reset = 1'b0;
        idle(1);
        check_reset_values();
        idle(1);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            idle(6);
            spi_ck = ~spi_ck;
        end
        spi_ck = 1'b0;
        idle(4);
        check("rst_ss_low_busy", busy, 1'b0);
        check("rst_ss_low_oe", spi_miso_oe, 1'b0);
        spi_ss_n = 1'b1;
        idle(10);
        mo = '{8'hC3};
        mi = '{8'h77};
        frame(mo, mi, 6, 0);
        check("after_reset_q", q, 8'hC3);

        // maximum rate, 16 incrementing bytes, random core answers
        pv = 8'($urandom);
        preset(pv);
        mo = {};
        mi = '{pv};
        for (int i = 0; i < 16; i++) begin
            pv = 8'($urandom);
            mo.push_back(8'(i));
            d_next.push_back(pv);
            if (i < 15) mi.push_back(pv);
        end
        frame(mo, mi, SYNC + 4, 0);
        d_next = {};

        // idle: SCK toggles while deselected
        for (int i = 0; i < 12; i++) begin
            idle(3);
            spi_ck = ~spi_ck;
            check("idle_miso", spi_miso, 1'b1);
            check("idle_oe", spi_miso_oe, 1'b0);
            check("idle_busy_tog", busy, 1'b0);
        end
        spi_ck = 1'b0;
        idle(10);

        // randomized frames
        for (int f = 0; f < 6; f++) begin
            len  = $urandom_range(5, 1);
            half = $urandom_range(9, SYNC + 4);
            pv   = 8'($urandom);
            preset(pv);
            mo = {};
            mi = '{pv};
            for (int i = 0; i < len; i++) begin
                mo.push_back(8'($urandom));
                pv = 8'($urandom);
                d_next.push_back(pv);
                if (i < len - 1) mi.push_back(pv);
            end
            frame(mo, mi, half, 0);
            d_next = {};
        end

        idle(20);
        check("rx_missing", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
